// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM bank request front end.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_DEPTH = 23;
  localparam int unsigned FRAME_CYCLES     = 8;

  typedef struct packed {
    logic                        we;
    logic [SDRAM_ADDR_DEPTH-1:0] addr;
    logic [7:0]                  wdata;
  } sdram_req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Single-clock request FIFO with show-ahead head; entries are sdram_req_t.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  sdram_req_t din_i,
  input  logic       pop_i,
  output sdram_req_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  sdram_req_t    mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sdram_bank_port.sv
// Per-bank front end: queues byte requests, presents one per controller frame
// at the sync cycle, and returns read data as a one-cycle response strobe.
module sdram_bank_port
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = SDRAM_ADDR_DEPTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_DEPTH-1:0] req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  busy,
  input  logic                  ctrl_rdy,
  input  logic                  ctrl_sync,
  output logic                  ctrl_rd,
  output logic                  ctrl_wr,
  output logic [ADDR_DEPTH-1:0] ctrl_addr,
  output logic [7:0]            ctrl_wdata,
  input  logic [7:0]            ctrl_rdata
);

  sdram_req_t push_req, head;
  logic       full, empty, push, pop, pop_rd;
  logic       ready_q;
  logic       rd_pend_q, rd_pend_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    push_req.we    = req_we;
    push_req.addr  = SDRAM_ADDR_DEPTH'(req_addr);
    push_req.wdata = req_wdata;
  end

  sdram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .din_i   (push_req),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // ready_q keeps req_ready low while reset is held, since the FIFO is already empty then
  assign req_ready  = ready_q && !full;
  assign push       = req_valid && req_ready;
  assign pop        = ctrl_sync && ctrl_rdy && !empty;
  assign pop_rd     = pop && !head.we;

  assign ctrl_rd    = !empty && !head.we;
  assign ctrl_wr    = !empty && head.we;
  assign ctrl_addr  = ADDR_DEPTH'(head.addr);
  assign ctrl_wdata = head.wdata;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign busy       = !empty || rd_pend_q;

  // Read data arrives one frame after issue; a read popping at that same sync keeps rd_pend set
  always_comb begin
    rd_pend_d   = rd_pend_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    if (ctrl_sync && rd_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = ctrl_rdata;
      rd_pend_d   = pop_rd;
    end else if (pop_rd) begin
      rd_pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ready_q     <= 1'b1;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_bank_port.sv
// Directed bench for sdram_bank_port with a simple frame/controller model.
module tb_sdram_bank_port;

  localparam int unsigned AD = 23;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, req_we;
  logic [AD-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          busy, ctrl_rdy, ctrl_sync, ctrl_rd, ctrl_wr;
  logic [AD-1:0] ctrl_addr;
  logic [7:0]    ctrl_wdata, ctrl_rdata;

  int n_vec = 0;
  int n_bad = 0;
  int unsigned cyc;

  logic [7:0]    mem [256];
  logic [AD-1:0] pend_addr;
  int            pop_cyc [$];
  logic          pop_we  [$];
  logic [AD-1:0] pop_addr[$];
  logic [7:0]    pop_wd  [$];
  int            rsp_cyc [$];
  logic [7:0]    rsp_dat [$];

  always #5 clk = ~clk;

  sdram_bank_port #(.ADDR_DEPTH(AD), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .ctrl_rdy   (ctrl_rdy),
    .ctrl_sync  (ctrl_sync),
    .ctrl_rd    (ctrl_rd),
    .ctrl_wr    (ctrl_wr),
    .ctrl_addr  (ctrl_addr),
    .ctrl_wdata (ctrl_wdata),
    .ctrl_rdata (ctrl_rdata)
  );

  // Controller model: sync every 8th cycle, byte memory, read data driven from the last issued read.
  initial begin
    logic          s_pop, s_we, s_rsp;
    logic [AD-1:0] s_addr;
    logic [7:0]    s_wd, s_rd;
    cyc        = 0;
    ctrl_sync  = 1'b0;
    ctrl_rdata = '0;
    pend_addr  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h91;
    forever begin
      @(negedge clk);
      s_pop  = ctrl_sync && ctrl_rdy && (ctrl_rd || ctrl_wr) && rst_n;
      s_we   = ctrl_wr;
      s_addr = ctrl_addr;
      s_wd   = ctrl_wdata;
      s_rsp  = rsp_valid;
      s_rd   = rsp_rdata;
      @(posedge clk);
      #1;
      if (s_pop) begin
        pop_cyc.push_back(int'(cyc));
        pop_we.push_back(s_we);
        pop_addr.push_back(s_addr);
        pop_wd.push_back(s_wd);
        if (s_we) mem[s_addr[7:0]] = s_wd;
        else      pend_addr = s_addr;
      end
      if (s_rsp) begin
        rsp_cyc.push_back(int'(cyc));
        rsp_dat.push_back(s_rd);
      end
      cyc        = cyc + 1;
      ctrl_sync  = ((cyc % 8) == 0);
      ctrl_rdata = mem[pend_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [AD-1:0] a, input logic [7:0] d,
                      output logic acc, output int c);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    acc       = req_ready;
    c         = int'(cyc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_phase(input int unsigned p);
    for (int i = 0; i < 16 && (cyc % 8) != p; i++) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 400 && int'(cyc) < target; i++) @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic acc_v[5];
    int   c, s, pb, rb;

    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 23'h001234;
    req_wdata = '0;
    ctrl_rdy  = 1'b1;

    // Reset held with a request offered
    repeat (20) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdwr", {ctrl_rd, ctrl_wr}, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("rel_ready", req_ready, 1);
    chk("rel_rdwr", {ctrl_rd, ctrl_wr}, 0);
    chk("rel_busy", busy, 0);
    chk("rel_pops", pop_cyc.size(), 0);
    chk("rel_rsps", rsp_cyc.size(), 0);

    // Single read mid-frame
    pb = pop_cyc.size(); rb = rsp_cyc.size();
    wait_phase(3);
    push(1'b0, 23'h001234, 8'h00, acc, c);
    chk("sr_acc", acc, 1);
    s = c + 5;
    wait_cyc(s);
    chk("sr_rd_at_sync", ctrl_rd, 1);
    chk("sr_addr", ctrl_addr, 23'h001234);
    chk("sr_busy", busy, 1);
    wait_cyc(s + 12);
    chk("sr_npop", pop_cyc.size() - pb, 1);
    chk("sr_pop_cyc", pop_cyc[pb], s);
    chk("sr_nrsp", rsp_cyc.size() - rb, 1);
    chk("sr_rsp_cyc", rsp_cyc[rb], s + 9);
    chk("sr_rsp_dat", rsp_dat[rb], 8'hA5);
    chk("sr_busy_after", busy, 0);

    // Back-to-back write / read / read
    pb = pop_cyc.size(); rb = rsp_cyc.size();
    wait_phase(3);
    push(1'b1, 23'h000010, 8'h3C, acc, c);
    chk("bb_acc0", acc, 1);
    s = c + 5;
    push(1'b0, 23'h000010, 8'h00, acc, c);
    chk("bb_acc1", acc, 1);
    push(1'b0, 23'h000011, 8'h00, acc, c);
    chk("bb_acc2", acc, 1);
    wait_cyc(s + 30);
    chk("bb_npop", pop_cyc.size() - pb, 3);
    chk("bb_pop0_cyc", pop_cyc[pb],     s);
    chk("bb_pop1_cyc", pop_cyc[pb + 1], s + 8);
    chk("bb_pop2_cyc", pop_cyc[pb + 2], s + 16);
    chk("bb_pop_we", {pop_we[pb], pop_we[pb + 1], pop_we[pb + 2]}, 3'b100);
    chk("bb_pop0_addr", pop_addr[pb],     23'h000010);
    chk("bb_pop0_wd",   pop_wd[pb],       8'h3C);
    chk("bb_pop2_addr", pop_addr[pb + 2], 23'h000011);
    chk("bb_nrsp", rsp_cyc.size() - rb, 2);
    chk("bb_rsp0_cyc", rsp_cyc[rb],     s + 17);
    chk("bb_rsp1_cyc", rsp_cyc[rb + 1], s + 25);
    chk("bb_rsp0_dat", rsp_dat[rb],     8'h3C);
    chk("bb_rsp1_dat", rsp_dat[rb + 1], 8'h80);
    chk("bb_rdata_hold", rsp_rdata, 8'h80);
    chk("bb_rsp_low", rsp_valid, 0);

    // Fill with controller not ready
    ctrl_rdy = 1'b0;
    pb = pop_cyc.size(); rb = rsp_cyc.size();
    wait_phase(1);
    for (int i = 0; i < 5; i++) begin
      push(1'b1, AD'(32 + i), 8'(96 + i), acc, c);
      acc_v[i] = acc;
    end
    chk("full_acc", {acc_v[0], acc_v[1], acc_v[2], acc_v[3], acc_v[4]}, 5'b11110);
    chk("full_ready", req_ready, 0);
    wait_cyc(int'(cyc) + 10);
    chk("full_nopop", pop_cyc.size() - pb, 0);
    chk("full_busy", busy, 1);
    wait_phase(4);
    ctrl_rdy = 1'b1;
    s = int'(cyc) + 4;
    wait_cyc(s);
    chk("full_ready_at_pop", req_ready, 0);
    @(negedge clk);
    chk("full_ready_after_pop", req_ready, 1);
    wait_cyc(s + 26);
    chk("full_npop", pop_cyc.size() - pb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("full_pop_cyc",  pop_cyc[pb + i],  s + 8 * i);
      chk("full_pop_addr", pop_addr[pb + i], AD'(32 + i));
    end
    chk("full_nrsp", rsp_cyc.size() - rb, 0);
    chk("full_busy_end", busy, 0);

    // Push on a sync cycle into an empty FIFO
    pb = pop_cyc.size();
    wait_phase(0);
    chk("ps_empty_wr", ctrl_wr, 0);
    push(1'b1, 23'h000040, 8'h55, acc, c);
    chk("ps_acc", acc, 1);
    wait_cyc(c + 10);
    chk("ps_npop", pop_cyc.size() - pb, 1);
    chk("ps_pop_cyc", pop_cyc[pb], c + 8);

    // Reset while a read is outstanding and writes are queued
    pb = pop_cyc.size(); rb = rsp_cyc.size();
    wait_phase(3);
    push(1'b0, 23'h000050, 8'h00, acc, c);
    s = c + 5;
    push(1'b1, 23'h000051, 8'h11, acc, c);
    push(1'b1, 23'h000052, 8'h22, acc, c);
    wait_cyc(s + 2);
    chk("rr_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rr_busy", busy, 0);
    chk("rr_ready_low", req_ready, 0);
    @(negedge clk);
    chk("rr_ready_back", req_ready, 1);
    wait_cyc(s + 40);
    chk("rr_npop", pop_cyc.size() - pb, 1);
    chk("rr_nrsp", rsp_cyc.size() - rb, 0);
    chk("rr_busy_end", busy, 0);
    chk("rr_rdata", rsp_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
